// File: rtl/regfile_dump_reader.sv
// Debug read-out engine: walks the register file read port and streams a
// header byte plus every register (LSB first) over a valid/ready byte channel.
module regfile_dump_reader #(
    parameter logic [7:0] HDR_BYTE = 8'hA5,
    parameter int         NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        rf_ena,
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LOAD,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    state_t      state_reg, state_next;
    logic [4:0]  idx_reg, idx_next;
    logic [1:0]  byte_cnt_reg, byte_cnt_next;
    logic [31:0] shreg_reg, shreg_next;

    logic xfer;
    logic at_last_reg;
    logic at_last_byte;

    assign xfer         = out_valid & out_ready;
    assign at_last_reg  = (idx_reg == LAST_IDX);
    assign at_last_byte = (byte_cnt_reg == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            idx_reg      <= 5'd0;
            byte_cnt_reg <= 2'd0;
            shreg_reg    <= 32'd0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            byte_cnt_reg <= byte_cnt_next;
            shreg_reg    <= shreg_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        byte_cnt_next = byte_cnt_reg;
        shreg_next    = shreg_reg;

        case (state_reg)
            S_IDLE: begin
                idx_next      = 5'd0;
                byte_cnt_next = 2'd0;
                shreg_next    = 32'd0;
                if (start) begin
                    state_next = S_HDR;
                end
            end
            S_HDR: begin
                if (xfer) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                shreg_next    = rf_rdata;
                byte_cnt_next = 2'd0;
                state_next    = S_SEND;
            end
            S_SEND: begin
                if (xfer) begin
                    shreg_next    = {8'd0, shreg_reg[31:8]};
                    byte_cnt_next = byte_cnt_reg + 2'd1;
                    if (at_last_byte) begin
                        // byte_cnt is parked at 0 rather than allowed to wrap
                        byte_cnt_next = 2'd0;
                        if (at_last_reg) begin
                            state_next = S_DONE;
                        end else begin
                            idx_next   = idx_reg + 5'd1;
                            state_next = S_LOAD;
                        end
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Every output is a pure decode of registered state, so reset clears them at once.
    always_comb begin
        busy      = (state_reg != S_IDLE);
        done      = (state_reg == S_DONE);
        rf_ena    = (state_reg == S_LOAD);
        rf_raddr  = (state_reg == S_LOAD) ? idx_reg : 5'd0;
        out_valid = 1'b0;
        out_data  = 8'd0;
        out_last  = 1'b0;
        case (state_reg)
            S_HDR: begin
                out_valid = 1'b1;
                out_data  = HDR_BYTE;
            end
            S_SEND: begin
                out_valid = 1'b1;
                out_data  = shreg_reg[7:0];
                out_last  = at_last_reg & at_last_byte;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: directed frames with a register
// file model, backpressure, start re-pulses, mid-frame reset and mid-dump writes.
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        out_ready = 1'b0;
    logic        busy, done, rf_ena, out_valid, out_last;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic [7:0]  out_data;

    logic [31:0] rf [32];
    logic [31:0] exp_rf [32];

    assign rf_rdata = rf_ena ? rf[rf_raddr] : 32'h0;

    always #5 clk = ~clk;

    regfile_dump_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rf_ena    (rf_ena),
        .rf_raddr  (rf_raddr),
        .rf_rdata  (rf_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor (samples on the falling edge) ----------------
    logic [7:0] got_data [$];
    logic       got_last [$];
    int         got_cyc  [$];
    int         addr_q   [$];
    int         cyc = 0;
    int         done_cnt = 0, done_cyc = -1;
    int         stall_cnt = 0, stable_err = 0, raddr_err = 0, ena_run_err = 0;
    logic       prev_stall = 1'b0, prev_ena = 1'b0;
    logic [7:0] prev_data = 8'd0;
    logic       busy162 = 1'b0, busy163 = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (cyc == 162) busy162 = busy;
        if (cyc == 163) busy163 = busy;
        if (start && !busy && rst_n) cyc = 0;
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_ena   = 1'b0;
        end else begin
            if (prev_stall && (!out_valid || out_data !== prev_data)) stable_err++;
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
                got_cyc.push_back(cyc);
            end
            if (out_valid && !out_ready) stall_cnt++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (rf_ena) begin
                addr_q.push_back(int'(rf_raddr));
                if (prev_ena) ena_run_err++;
            end else if (rf_raddr != 5'd0) begin
                raddr_err++;
            end
            prev_ena = rf_ena;
        end
    end

    task automatic clear_mon();
        got_data.delete();
        got_last.delete();
        got_cyc.delete();
        addr_q.delete();
        done_cnt = 0; done_cyc = -1;
        stall_cnt = 0; stable_err = 0; raddr_err = 0; ena_run_err = 0;
    endtask

    // ---------------- reference model of the frame ----------------
    function automatic logic [7:0] exp_byte(input int pos);
        int i, b;
        if (pos == 0) return 8'hA5;
        i = (pos - 1) / 4;
        b = (pos - 1) % 4;
        return exp_rf[i][8*b +: 8];
    endfunction

    function automatic logic [7:0] byte_at(input int pos);
        if (pos < got_data.size()) return got_data[pos];
        return 8'hxx;
    endfunction

    task automatic compare_frame(input string name);
        int mism = 0;
        int lastbad = 0;
        check({name, "_len"}, 32'(got_data.size()), 32'd129);
        for (int p = 0; p < got_data.size(); p++) begin
            if (got_data[p] !== exp_byte(p)) mism++;
            if (got_last[p] !== (p == 128)) lastbad++;
        end
        check({name, "_bytes"}, 32'(mism), 32'd0);
        check({name, "_last"}, 32'(lastbad), 32'd0);
    endtask

    task automatic check_reads(input string name);
        int abad = 0;
        check({name, "_rd_count"}, 32'(addr_q.size()), 32'd32);
        for (int k = 0; k < addr_q.size(); k++) begin
            if (addr_q[k] != k) abad++;
        end
        check({name, "_rd_order"}, 32'(abad), 32'd0);
        check({name, "_rd_pulse"}, 32'(ena_run_err), 32'd0);
        check({name, "_raddr_idle"}, 32'(raddr_err), 32'd0);
    endtask

    // ---------------- stimulus helpers ----------------
    // Leaves the bench at posedge+1 of cycle 1 (start sampled at edge 0).
    task automatic start_frame();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // mode 0: out_ready=1; mode 1: out_ready random at 30% duty.
    task automatic run_until_idle(input int mode, input int maxc, input string name);
        logic ok = 1'b0;
        for (int k = 0; k < maxc; k++) begin
            out_ready = (mode == 1) ? ($urandom_range(0, 9) < 3) : 1'b1;
            @(posedge clk); #1;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        out_ready = 1'b1;
        check({name, "_finished"}, 32'(ok), 32'd1);
    endtask

    typedef struct {
        int         pos;
        logic [7:0] data;
        logic       last;
        int         cyc;
    } vec_t;

    vec_t vecs [11];

    initial begin
        vecs[0]  = '{0,   8'hA5, 1'b0, 1};
        vecs[1]  = '{1,   8'h00, 1'b0, 3};
        vecs[2]  = '{4,   8'h00, 1'b0, 6};
        vecs[3]  = '{5,   8'h01, 1'b0, 8};
        vecs[4]  = '{8,   8'h11, 1'b0, 11};
        vecs[5]  = '{9,   8'h02, 1'b0, 13};
        vecs[6]  = '{12,  8'h12, 1'b0, 16};
        vecs[7]  = '{65,  8'h10, 1'b0, 83};
        vecs[8]  = '{68,  8'h20, 1'b0, 86};
        vecs[9]  = '{125, 8'h1F, 1'b0, 158};
        vecs[10] = '{128, 8'h2F, 1'b1, 161};

        for (int i = 0; i < 32; i++) begin
            rf[i] = (i == 0) ? 32'h0 : 32'(32'h0101_0101 * i) + 32'h1000_0000;
            exp_rf[i] = rf[i];
        end

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rf_ena", 32'(rf_ena), 32'd0);
        check("rst_rf_raddr", 32'(rf_raddr), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("idle_after_rst", 32'(busy), 32'd0);

        // ---- full dump, out_ready=1 ----
        clear_mon();
        start_frame();
        run_until_idle(0, 400, "full");
        for (int v = 0; v < 11; v++) begin
            check($sformatf("vec%0d_data", v), 32'(byte_at(vecs[v].pos)), 32'(vecs[v].data));
            check($sformatf("vec%0d_last", v),
                  (vecs[v].pos < got_last.size()) ? 32'(got_last[vecs[v].pos]) : 32'hFFFF_FFFF,
                  32'(vecs[v].last));
            check($sformatf("vec%0d_cycle", v),
                  (vecs[v].pos < got_cyc.size()) ? 32'(got_cyc[vecs[v].pos]) : 32'hFFFF_FFFF,
                  32'(vecs[v].cyc));
        end
        compare_frame("full");
        check_reads("full");
        check("full_done_cycle", 32'(done_cyc), 32'd162);
        check("full_done_count", 32'(done_cnt), 32'd1);

        // ---- backpressure ----
        clear_mon();
        start_frame();
        run_until_idle(1, 3000, "bp");
        compare_frame("bp");
        check("bp_stable", 32'(stable_err), 32'd0);
        check("bp_had_stalls", 32'(stall_cnt > 0), 32'd1);
        check("bp_done_cycle", 32'(done_cyc), 32'(162 + stall_cnt));
        check("bp_done_count", 32'(done_cnt), 32'd1);

        // ---- start re-pulsed at cycles 10, 80, 162; fresh start at 163 ----
        clear_mon();
        out_ready = 1'b1;
        start_frame();
        repeat (9) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (69) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (81) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 start = 1'b0;
        compare_frame("rep");
        check_reads("rep");
        check("rep_done_cycle", 32'(done_cyc), 32'd162);
        check("rep_done_count", 32'(done_cnt), 32'd1);
        check("rep_busy_c162", 32'(busy162), 32'd1);
        check("rep_busy_c163", 32'(busy163), 32'd0);
        clear_mon();
        run_until_idle(0, 400, "fresh");
        compare_frame("fresh");
        check("fresh_done_cycle", 32'(done_cyc), 32'd162);

        // ---- reset during SEND of r7 byte 2 (cycle 40) ----
        clear_mon();
        start_frame();
        repeat (39) @(posedge clk);
        #1;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_data", 32'(out_data), 32'h07);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rf_ena", 32'(rf_ena), 32'd0);
        check("mid_rst_last", 32'(out_last), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_idle", 32'(busy), 32'd0);
        check("rst_no_done", 32'(done_cnt), 32'd0);
        check("rst_partial_len", 32'(got_data.size()), 32'd31);
        begin
            int nlast = 0;
            for (int p = 0; p < got_last.size(); p++) if (got_last[p]) nlast++;
            check("rst_no_last", 32'(nlast), 32'd0);
        end
        clear_mon();
        start_frame();
        run_until_idle(0, 400, "after_rst");
        compare_frame("after_rst");
        check("after_rst_done_cycle", 32'(done_cyc), 32'd162);

        // ---- mid-dump writes: r3 after its LOAD (cycle 17), r20 before (cycle 102) ----
        clear_mon();
        start_frame();
        repeat (29) @(posedge clk);
        @(negedge clk) rf[3] = 32'hCAFE_F00D;
        repeat (20) @(posedge clk);
        @(negedge clk) rf[20] = 32'hDEAD_BEEF;
        exp_rf[20] = 32'hDEAD_BEEF;
        run_until_idle(0, 400, "wr");
        compare_frame("wr");
        check("wr_r20_b0", 32'(byte_at(81)), 32'hEF);
        check("wr_r20_b1", 32'(byte_at(82)), 32'hBE);
        check("wr_r20_b2", 32'(byte_at(83)), 32'hAD);
        check("wr_r20_b3", 32'(byte_at(84)), 32'hDE);
        check("wr_r3_b0", 32'(byte_at(13)), 32'h03);
        check("wr_r3_b3", 32'(byte_at(16)), 32'h13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Debug read-out engine for the CPU's 32×32 register file. On a start pulse it reads registers 0–31 through the register file's read port, one register at a time. It streams them as a byte frame over a valid/ready channel: a header byte, then each register's four bytes, least-significant byte first. It sits beside the core and drives the read-address/enable side of the register file. Its byte stream feeds the debug UART/host link.

## Interface
Parameters:
- HDR_BYTE, 8'hA5, first byte of every frame.
- NUM_REGS, 32, number of registers dumped, starting at address 0. Legal range is 1–32.

Ports:
- clk, input, 1, system clock. All state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- start, input, 1, single-cycle request to begin a dump. Sampled only in IDLE.
- busy, output, 1, high whenever state ≠ IDLE.
- done, output, 1, one-cycle pulse after the last byte is accepted.
- rf_ena, output, 1, register-file read enable.
- rf_raddr, output, 5, register-file read address.
- rf_rdata, input, 32, register-file read data. Combinational from rf_raddr when rf_ena=1.
- out_valid, output, 1, byte available.
- out_ready, input, 1, sink accepts the byte.
- out_data, output, 8, stream byte.
- out_last, output, 1, marks the final byte of the frame. Qualified by out_valid.

## Operation
- Handshake: a byte transfers on a rising edge where out_valid & out_ready = 1.
  - Once out_valid rises, out_valid, out_data and out_last hold stable until that transfer.
  - out_valid never depends combinationally on out_ready.
- State machine: IDLE → HDR → LOAD → SEND → (LOAD | DONE) → IDLE.
  - IDLE: all outputs low. start=1 → HDR. idx and byte_cnt are cleared.
  - HDR: out_valid=1, out_data=HDR_BYTE, out_last=0. On transfer → LOAD.
  - LOAD: rf_ena=1, rf_raddr=idx. At the clock edge, rf_rdata is captured into a 32-bit shift register, byte_cnt=0, and the state goes to SEND. out_valid=0 in this state.
  - SEND: out_valid=1, out_data=shreg[7:0].
    - On transfer, shreg shifts right 8 bits and byte_cnt increments.
    - On the transfer with byte_cnt=3: if idx=NUM_REGS−1 → DONE; else idx+1 and → LOAD.
  - DONE: done=1 for exactly one cycle, then → IDLE.
- out_last=1 only in SEND with idx=NUM_REGS−1 and byte_cnt=3.
- rf_ena is high only in LOAD, decoded from the state register. rf_raddr=idx in LOAD and 0 otherwise.
- idx is 5 bits and byte_cnt is 2 bits. Neither wraps within a frame; both reset to 0 in IDLE.
- Frame length is 1 + 4·NUM_REGS bytes (129 at the default).
- Consistency: each register is sampled at its own LOAD edge, so the dump is not an atomic snapshot.
  - Core writes occur on the falling edge in the register file. A write that lands before a register's LOAD edge appears in the dump; a later write does not.
- start while busy=1 is ignored. It is neither queued nor restarts the frame.
- start asserted in the same cycle as done is ignored. The block is in DONE that cycle, not IDLE.

## Timing
- Reset values: state=IDLE, busy=0, done=0, rf_ena=0, rf_raddr=0, out_valid=0, out_data=0, out_last=0. idx, byte_cnt and shreg are all 0.
- Latency with out_ready held at 1, where start is sampled at edge 0:
  - HDR is valid in cycle 1.
  - LOAD r0 is in cycle 2.
  - r0 bytes are in cycles 3–6.
  - Register i is loaded in cycle 2+5i.
  - The last byte is in cycle 5·NUM_REGS+1 (161 at the default).
  - done is in cycle 162 and IDLE in cycle 163.
- Minimum cost is 5 cycles per register. Each stall cycle (out_ready=0 while out_valid=1) adds exactly one cycle.
- rst_n low at any point, including mid-frame:
  - All outputs clear asynchronously and the partial frame is abandoned. No out_last and no done are issued for it.
  - After rst_n rises, the block stays in IDLE until a new start.

## Test plan
- Full dump, out_ready=1: preload r[i]=32'h0101_0101·i + 32'h1000_0000 (r0 reads 0).
  - Required response: 129 bytes. Bytes are A5, then 00 00 00 00 for r0, then 01 01 01 11 for r1, and so on.
  - out_last is set on byte 129 only. done arrives in cycle 162 with a single-cycle pulse.
- Backpressure: out_ready random at 30% duty.
  - Required response: byte sequence identical to the previous test. out_valid and out_data never change while stalled.
  - Total cycles = 162 + number of stall cycles.
- Read-port check: monitor rf_ena and rf_raddr.
  - Required response: exactly 32 single-cycle rf_ena pulses with addresses 0..31 in order. rf_raddr=0 whenever rf_ena=0.
- start re-pulsed at cycles 10, 80 and 162 of a frame.
  - Required response: the frame continues unchanged, and busy drops only after done.
  - A new start in cycle 163 begins a fresh frame with A5.
- rst_n asserted low during SEND of r7, byte 2.
  - Required response: out_valid, busy and rf_ena fall immediately, and no done is issued.
  - The next start produces a complete frame from A5 and r0.
- Mid-dump write: the core writes r20=DEADBEEF before r20's LOAD edge, and writes r3 after r3's LOAD edge.
  - Required response: the dump shows EF BE AD DE for r20 and the old value for r3.
